// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing one synchronous data memory between a core (A) and a DMA/debug port (B).
// Define DMEM_ARB_RR_EN for round-robin contention; otherwise A has priority with a B starvation limit.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic [31:0] a_add,
  input  logic [3:0]  a_wen,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic [31:0] b_add,
  input  logic [3:0]  b_wen,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  output logic [31:0] m_add,
  output logic [3:0]  m_wen,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  logic a_win, b_win;
  logic a_rvalid_q, a_rvalid_d;
  logic b_rvalid_q, b_rvalid_d;

`ifdef DMEM_ARB_RR_EN
  logic last_b_q, last_b_d;  // 1 = B was granted most recently
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt_q, starve_cnt_d;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    a_win = 1'b0;
    b_win = 1'b0;
    if (reset) begin
      if (a_req && b_req) begin
`ifdef DMEM_ARB_RR_EN
        if (last_b_q) a_win = 1'b1;
        else          b_win = 1'b1;
`else
        if (starve_cnt_q == LIMIT) b_win = 1'b1;
        else                       a_win = 1'b1;
`endif
      end else begin
        a_win = a_req;
        b_win = b_req;
      end
    end
  end

  assign a_gnt = a_win;
  assign b_gnt = b_win;

  always_comb begin
    m_add   = 32'h0;
    m_wen   = 4'h0;
    m_wdata = 32'h0;
    if (a_win) begin
      m_add   = a_add;
      m_wen   = a_wen;
      m_wdata = a_wdata;
    end else if (b_win) begin
      m_add   = b_add;
      m_wen   = b_wen;
      m_wdata = b_wdata;
    end
  end

  always_comb begin
    a_rvalid_d = a_win && (a_wen == 4'h0);
    b_rvalid_d = b_win && (b_wen == 4'h0);
`ifdef DMEM_ARB_RR_EN
    last_b_d = last_b_q;
    if (a_win)      last_b_d = 1'b0;
    else if (b_win) last_b_d = 1'b1;
`else
    starve_cnt_d = 4'h0;
    if (b_req && !b_win)
      starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q : starve_cnt_q + 4'h1;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_b_q   <= 1'b1;
`else
      starve_cnt_q <= 4'h0;
`endif
    end else begin
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
`ifdef DMEM_ARB_RR_EN
      last_b_q   <= last_b_d;
`else
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

  // Reset arriving the cycle after a read must hide that read's response.
  assign a_rvalid = a_rvalid_q & reset;
  assign b_rvalid = b_rvalid_q & reset;
  assign a_rdata  = m_rdata;
  assign b_rdata  = m_rdata;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive denied contending cycles for port B before B is forced a grant (range 1..15).
REQ-002 The block SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-low reset (0 = reset asserted).
REQ-004 The block SHALL have ports a_req input 1, a_add input 32, a_wen input 4, a_wdata input 32: core load/store request (a_wen=0 read, nonzero byte-lane write).
REQ-005 The block SHALL have ports a_gnt output 1 (request accepted this cycle), a_rvalid output 1 (read data valid), a_rdata output 32.
REQ-006 The block SHALL have ports b_req, b_add, b_wen, b_wdata, b_gnt, b_rvalid, b_rdata with the same widths and meanings for the DMA/debug requester.
REQ-007 The block SHALL have ports m_add output 32, m_wen output 4, m_wdata output 32, m_rdata input 32 driving the shared data memory (memory registers read data on clk, writes on clk with byte-lane merge).

Function
REQ-008 Grant SHALL be combinational: x_gnt=1 in the same cycle x_req=1 and x_wins; at most one of a_gnt/b_gnt high per cycle.
REQ-009 Winner's add/wen/wdata SHALL drive m_add/m_wen/m_wdata combinationally; with no grant m_add=0, m_wen=0, m_wdata=0.
REQ-010 A granted read (wen=0) SHALL produce x_rvalid=1 exactly one cycle later, for exactly one cycle; granted writes SHALL produce no rvalid.
REQ-011 a_rdata and b_rdata SHALL both equal m_rdata; contents are meaningful only when the matching rvalid is 1.
REQ-012 Throughput SHALL be one accepted request per cycle; back-to-back grants to either or alternating ports SHALL be allowed with no bubble.
REQ-013 Single requester SHALL always be granted immediately.
REQ-014 Contention (a_req=b_req=1), default policy: A wins unless starve_cnt==STARVE_LIMIT, in which case B wins.
REQ-015 starve_cnt (4 bits) SHALL increment on each cycle with b_req=1 and b_gnt=0, saturate at STARVE_LIMIT, clear to 0 on b_gnt=1 or b_req=0.
REQ-016 Requester SHALL hold req/add/wen/wdata stable until granted; the block SHALL NOT latch ungranted requests.
REQ-017 A write followed by a read to the same word in the next cycle SHALL return the newly written data (memory write-then-read order; no bypass needed in the arbiter).

Reset
REQ-018 While reset=0 at a rising edge: a_rvalid=b_rvalid=0, starve_cnt=0, last_winner=B after that edge.
REQ-019 While reset=0, a_gnt=b_gnt=0 and m_wen=0 combinationally, so no memory write occurs during reset.
REQ-020 Reset asserted in the cycle after a granted read SHALL suppress that read's rvalid.

Configuration
REQ-021 Macro DMEM_ARB_RR_EN defined: contention SHALL be resolved round-robin using last_winner (grant the port not granted last; last_winner updates on every grant); starve_cnt and STARVE_LIMIT logic SHALL be absent.
REQ-022 DMEM_ARB_RR_EN undefined: fixed A priority with starvation counter per REQ-014/015; last_winner logic SHALL be absent.

Verification
REQ-023 Reset=0 for 2 cycles with a_req=1,a_wen=4'hF -> a_gnt=0, m_wen=0, memory word unchanged, rvalid=0.
REQ-024 A writes 32'hDEADBEEF, wen=4'hF to 0x100, next cycle A reads 0x100 -> a_gnt=1 both cycles, a_rvalid=1 in cycle 3 with a_rdata=32'hDEADBEEF, b_rvalid=0.
REQ-025 A byte write wen=4'b0010, wdata=32'h0000AB00 to 0x100 then read -> a_rdata=32'hDEADABEF.
REQ-026 Default build, STARVE_LIMIT=4, a_req=b_req=1 continuously (reads) -> grant pattern A,A,A,A,B repeating; b_rvalid one cycle after each b_gnt.
REQ-027 DMEM_ARB_RR_EN build, both requesting continuously from reset -> A,B,A,B...; b_req only -> B every cycle.
REQ-028 B granted read at cycle n, reset=0 at cycle n+1 -> b_rvalid=0 at n+1, starve_cnt=0 afterwards.
